// File: rtl/cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
//   cmp_state_t : controller state encoding (IDLE / RUN / FIN)
//   clog2       : ceiling log2 used to size the digit index register
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } cmp_state_t;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice pair.
//   a, b         : slices of operand A and operand B
//   lt_c/eq_c/gt_c : a<b, a==b, a>b (exactly one is high)
module cmp_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt_c,
    output logic             eq_c,
    output logic             gt_c
);

    assign lt_c = (a < b);
    assign eq_c = (a == b);
    assign gt_c = (a > b);

endmodule

// File: rtl/cmp_seq_nb.sv
// Digit-serial magnitude comparator: compares x and y MSB-first, DIGIT bits
// per cycle, stopping at the first differing digit. Results are held until
// the next accepted start.
//   clk, rst     : clock and synchronous active-high reset
//   start        : request, accepted in IDLE or FIN
//   sgn          : two's-complement mode (only when CMP_SIGNED_EN is defined)
//   x, y         : operands, latched on the accepting edge
//   busy         : high while comparing (RUN)
//   done         : one-cycle pulse in FIN
//   lt, eq, gt   : comparison result of the latched operands
// Optional feature macro: CMP_SIGNED_EN (adds the sgn port / signed ordering).
module cmp_seq_nb
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CMP_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IDXW = (NDIG > 1) ? clog2(NDIG) : 1;

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
`ifdef CMP_SIGNED_EN
    logic             sgn_q, sgn_d;
    logic             top_dig;
`endif

    logic [DIGIT-1:0] x_dig, y_dig;
    logic             dig_lt_c, dig_eq_c, dig_gt_c;

    // Select the current digit pair; signed mode flips the operand MSBs on
    // the top digit so offset-binary unsigned ordering gives signed order.
    always_comb begin
        x_dig = '0;
        y_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDXW'(i)) begin
                x_dig = x_q[i*DIGIT +: DIGIT];
                y_dig = y_q[i*DIGIT +: DIGIT];
            end
        end
`ifdef CMP_SIGNED_EN
        top_dig = (idx_q == IDXW'(NDIG - 1));
        if (sgn_q && top_dig) begin
            x_dig[DIGIT-1] = ~x_dig[DIGIT-1];
            y_dig[DIGIT-1] = ~y_dig[DIGIT-1];
        end
`endif
    end

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (x_dig),
        .b    (y_dig),
        .lt_c (dig_lt_c),
        .eq_c (dig_eq_c),
        .gt_c (dig_gt_c)
    );

    // Next-state, operand capture and result logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
`ifdef CMP_SIGNED_EN
        sgn_d   = sgn_q;
`endif

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = x;
                    y_d     = y;
`ifdef CMP_SIGNED_EN
                    sgn_d   = sgn;
`endif
                    idx_d   = IDXW'(NDIG - 1);
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!dig_eq_c) begin
                    state_d = FIN;
                    lt_d    = dig_lt_c;
                    gt_d    = dig_gt_c;
                    eq_d    = 1'b0;
                end else if (idx_q == '0) begin
                    state_d = FIN;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered decodes of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
`ifdef CMP_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
`ifdef CMP_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_cmp_seq_nb.sv
// Testbench for cmp_seq_nb (WIDTH=16, DIGIT=2): transaction-level reference
// model checked every cycle, plus directed cases with literal expectations.
module tb_cmp_seq_nb;

    localparam int WIDTH = 16;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

    logic              clk;
    logic              rst;
    logic              start;
    logic              sgn_i;
    logic [WIDTH-1:0]  x_i;
    logic [WIDTH-1:0]  y_i;
    logic              busy, done, lt, eq, gt;

    int checks;
    int failures;
    bit chk_en;

    cmp_seq_nb #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef CMP_SIGNED_EN
        .sgn   (sgn_i),
`endif
        .x     (x_i),
        .y     (y_i),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ordering by plain arithmetic; latency = 1-based position of
    // the first differing DIGIT-bit group from the MSB (NDIG when equal).
    function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s, output logic r_lt, output logic r_eq,
                                    output logic r_gt, output int k);
        logic [DIGIT-1:0] da, db;
        bit found;
        r_eq = (a == b);
        if (s) r_lt = ($signed(a) < $signed(b));
        else   r_lt = (a < b);
        r_gt = !r_lt && !r_eq;
        k = NDIG;
        found = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            da = a[(NDIG-1-i)*DIGIT +: DIGIT];
            db = b[(NDIG-1-i)*DIGIT +: DIGIT];
            if (!found && da != db) begin
                k = i + 1;
                found = 1'b1;
            end
        end
    endfunction

    // Model state: expected outputs after each rising edge.
    logic m_busy, m_done, m_lt, m_eq, m_gt;
    logic p_lt, p_eq, p_gt;
    int   m_rem, p_k;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_lt = 0; m_eq = 0; m_gt = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_lt = p_lt; m_eq = p_eq; m_gt = p_gt;
                end
            end else if (start) begin
                ref_cmp(x_i, y_i, sgn_i, p_lt, p_eq, p_gt, p_k);
                m_rem  = p_k;
                m_busy = 1;
                m_lt = 0; m_eq = 0; m_gt = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("lt", lt, m_lt);
            chk("eq", eq, m_eq);
            chk("gt", gt, m_gt);
        end
    end

    // Called at a falling edge: present a one-cycle start pulse.
    task automatic start_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        x_i = a; y_i = b; sgn_i = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done (bounded); also counts busy cycles.
    task automatic wait_done(input string name, output int n, output int nbusy);
        bit got;
        n = 0; nbusy = 0; got = 0;
        while (n < 40 && !got) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        if (!got) chk_int({name, "_timeout"}, n, -1);
    endtask

    int n, nb;

    initial begin
        rst = 1'b1; start = 1'b0; sgn_i = 1'b0; x_i = '0; y_i = '0;
        checks = 0; failures = 0; chk_en = 0;
        @(negedge clk);
        chk_en = 1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_eq", eq, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: equal operands run all 8 digits
        start_txn(16'hA5A5, 16'hA5A5, 1'b0);
        wait_done("t1", n, nb);
        chk_int("t1_latency", n, 8);
        chk_int("t1_busy_cycles", nb, 8);
        chk("t1_eq", eq, 1'b1);
        chk("t1_lt", lt, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_hold_eq", eq, 1'b1);
        chk("t1_idle_busy", busy, 1'b0);

        // 2: difference in the top digit exits after one cycle
        start_txn(16'h8000, 16'h7FFF, 1'b0);
        wait_done("t2", n, nb);
        chk_int("t2_latency", n, 1);
        chk("t2_gt", gt, 1'b1);
        chk("t2_eq", eq, 1'b0);
        @(negedge clk);

        // 3: difference only in the bottom digit
        start_txn(16'h0001, 16'h0002, 1'b0);
        wait_done("t3", n, nb);
        chk_int("t3_latency", n, 8);
        chk("t3_lt", lt, 1'b1);
        @(negedge clk);

        // 4: start/operand changes mid-RUN are ignored; first differing
        // 2-bit digit of 0x00F0 vs 0x00E0 is the 6th from the MSB
        start_txn(16'h00F0, 16'h00E0, 1'b0);
        @(negedge clk);
        x_i = 16'h0000; y_i = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", n, nb);
        chk_int("t4_latency", n + 2, 6);
        chk("t4_gt", gt, 1'b1);

        // 5: start held in the FIN cycle goes straight back to RUN
        start_txn(16'h0003, 16'h0003, 1'b0);
        chk("t5_busy", busy, 1'b1);
        chk("t5_cleared_gt", gt, 1'b0);
        wait_done("t5", n, nb);
        chk_int("t5_latency", n, 8);
        chk("t5_eq", eq, 1'b1);
        @(negedge clk);

        // 4b: reset mid-RUN aborts with no done
        start_txn(16'h00F0, 16'h00E0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4b_busy", busy, 1'b0);
        chk("t4b_done", done, 1'b0);
        chk("t4b_gt", gt, 1'b0);
        chk("t4b_lt", lt, 1'b0);
        repeat (8) @(negedge clk);
        chk("t4b_no_done", done, 1'b0);

`ifdef CMP_SIGNED_EN
        // 6: signed ordering vs unsigned for the same operands
        start_txn(16'h8000, 16'h7FFF, 1'b1);
        wait_done("t6s", n, nb);
        chk_int("t6s_latency", n, 1);
        chk("t6s_lt", lt, 1'b1);
        @(negedge clk);
        start_txn(16'h8000, 16'h7FFF, 1'b0);
        wait_done("t6u", n, nb);
        chk("t6u_gt", gt, 1'b1);
        @(negedge clk);
`endif

        // extra: x<y differing in the top digit
        start_txn(16'h4000, 16'hC000, 1'b0);
        wait_done("t7", n, nb);
        chk_int("t7_latency", n, 1);
        chk("t7_lt", lt, 1'b1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
